// File: rtl/cdb_pkg.sv
// Shared widths and the result message carried from the functional units to the common data bus.
package cdb_pkg;

  localparam int unsigned CDB_DATA_W = 8;
  localparam int unsigned CDB_TAG_W  = 4;
  localparam int unsigned CDB_ROB_W  = 8;

  typedef struct packed {
    logic [CDB_DATA_W-1:0] val;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_ROB_W-1:0]  robid;
  } cdb_msg_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU result FIFO. Pointers carry an extra wrap bit so full and empty are told apart
// by pointer comparison alone.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push,
  input  cdb_msg_t din,
  input  logic     pop,
  output cdb_msg_t dout,
  output logic     empty,
  output logic     full
);

  localparam int unsigned PtrW  = $clog2(Depth) + 1;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  cdb_msg_t        mem_q [Depth];
  logic            push_en, pop_en;

  function automatic logic [AddrW-1:0] slot(input logic [PtrW-1:0] p);
    return AddrW'(32'(p) % Depth);
  endfunction

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q - rd_ptr_q) == PtrW'(Depth));
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign dout    = mem_q[slot(rd_ptr_q)];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      // Emptying only needs the read pointer to catch up with the write pointer.
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[slot(wr_ptr_q)] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers FU results per source and broadcasts one per cycle,
// chosen round-robin, through a registered output stage.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned FU_COUNT  = 8,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [FU_COUNT-1:0]                   fu_result_valid,
  input  logic [FU_COUNT-1:0][CDB_DATA_W-1:0]   fu_result_val,
  input  logic [FU_COUNT-1:0][CDB_TAG_W-1:0]    fu_result_tag,
  input  logic [FU_COUNT-1:0][CDB_ROB_W-1:0]    fu_result_robid,
  output logic [FU_COUNT-1:0]                   fu_result_ready,
  output logic [CDB_DATA_W-1:0]                 cdbval,
  output logic [CDB_TAG_W-1:0]                  cdbid,
  output logic [CDB_ROB_W-1:0]                  cdbrobid,
  output logic                                  cdbtransmit
);

  localparam int unsigned RrW = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  logic [FU_COUNT-1:0] fifo_empty, fifo_full, fifo_pop;
  cdb_msg_t            heads [FU_COUNT];

  logic [RrW-1:0] rr_ptr_q, rr_ptr_d;
  logic           tx_q, tx_d;
  cdb_msg_t       msg_q, msg_d;

  logic           grant_valid;
  logic [RrW-1:0] grant_idx;
  logic [RrW-1:0] cand;

  for (genvar g = 0; g < FU_COUNT; g++) begin : gen_fifo
    cdb_msg_t din;
    assign din = '{val: fu_result_val[g], tag: fu_result_tag[g], robid: fu_result_robid[g]};

    cdb_fifo #(
      .Depth(BUF_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .push (fu_result_valid[g]),
      .din  (din),
      .pop  (fifo_pop[g]),
      .dout (heads[g]),
      .empty(fifo_empty[g]),
      .full (fifo_full[g])
    );
  end

  // Ready depends only on registered occupancy; a pop never frees a slot the same cycle.
  assign fu_result_ready = ~fifo_full;

  // Rotating priority: first non-empty FIFO at or after rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < FU_COUNT; k++) begin
      cand = RrW'((32'(rr_ptr_q) + k) % FU_COUNT);
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    rr_ptr_d = rr_ptr_q;
    tx_d     = 1'b0;
    msg_d    = msg_q;
    if (!flush && grant_valid) begin
      fifo_pop[grant_idx] = 1'b1;
      tx_d                = 1'b1;
      msg_d               = heads[grant_idx];
      rr_ptr_d            = RrW'((32'(grant_idx) + 1) % FU_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      tx_q     <= 1'b0;
      msg_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tx_q     <= tx_d;
      msg_q    <= msg_d;
    end
  end

  assign cdbtransmit = tx_q;
  assign cdbval      = msg_q.val;
  assign cdbid       = msg_q.tag;
  assign cdbrobid    = msg_q.robid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised bench for cdb_arbiter against a queue-based reference model of the bus behaviour.
module tb_cdb_arbiter;

  localparam int unsigned FuCount  = 8;
  localparam int unsigned BufDepth = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         flush;
  logic [FuCount-1:0]           fu_valid;
  logic [FuCount-1:0][7:0]      fu_val;
  logic [FuCount-1:0][3:0]      fu_tag;
  logic [FuCount-1:0][7:0]      fu_rob;
  logic [FuCount-1:0]           fu_ready;
  logic [7:0]                   cdbval;
  logic [3:0]                   cdbid;
  logic [7:0]                   cdbrobid;
  logic                         cdbtransmit;

  cdb_arbiter #(
    .FU_COUNT (FuCount),
    .BUF_DEPTH(BufDepth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fu_result_valid(fu_valid),
    .fu_result_val  (fu_val),
    .fu_result_tag  (fu_tag),
    .fu_result_robid(fu_rob),
    .fu_result_ready(fu_ready),
    .cdbval         (cdbval),
    .cdbid          (cdbid),
    .cdbrobid       (cdbrobid),
    .cdbtransmit    (cdbtransmit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one bounded queue per FU holding {val, tag, robid}.
  logic [19:0] model_q [FuCount][$];
  int          model_rr = 0;
  logic        exp_tx   = 1'b0;
  logic [7:0]  exp_val  = '0;
  logic [3:0]  exp_tag  = '0;
  logic [7:0]  exp_rob  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    rst      = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    fu_val   = '0;
    fu_tag   = '0;
    fu_rob   = '0;
  endtask

  // Advance one clock: predict the edge from the model, then compare the DUT after it.
  task automatic tick();
    logic [FuCount-1:0] exp_ready;
    logic [19:0]        m;
    int                 g;
    for (int i = 0; i < FuCount; i++) exp_ready[i] = (model_q[i].size() < BufDepth);
    check("ready", 32'(fu_ready), 32'(exp_ready));
    if (rst) begin
      for (int i = 0; i < FuCount; i++) model_q[i].delete();
      model_rr = 0;
      exp_tx   = 1'b0;
      exp_val  = '0;
      exp_tag  = '0;
      exp_rob  = '0;
    end else if (flush) begin
      for (int i = 0; i < FuCount; i++) model_q[i].delete();
      exp_tx = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < FuCount; k++) begin
        int c;
        c = (model_rr + k) % FuCount;
        if (g < 0 && model_q[c].size() > 0) g = c;
      end
      if (g >= 0) begin
        m        = model_q[g].pop_front();
        exp_val  = m[19:12];
        exp_tag  = m[11:8];
        exp_rob  = m[7:0];
        exp_tx   = 1'b1;
        model_rr = (g + 1) % FuCount;
      end else begin
        exp_tx = 1'b0;
      end
      for (int i = 0; i < FuCount; i++)
        if (fu_valid[i] && exp_ready[i]) model_q[i].push_back({fu_val[i], fu_tag[i], fu_rob[i]});
    end
    @(posedge clk);
    #1;
    check("cdbtransmit", 32'(cdbtransmit), 32'(exp_tx));
    check("cdbval", 32'(cdbval), 32'(exp_val));
    check("cdbid", 32'(cdbid), 32'(exp_tag));
    check("cdbrobid", 32'(cdbrobid), 32'(exp_rob));
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_fu(input int i, input logic [7:0] v, input logic [3:0] t,
                          input logic [7:0] r);
    fu_valid[i] = 1'b1;
    fu_val[i]   = v;
    fu_tag[i]   = t;
    fu_rob[i]   = r;
  endtask

  int  pending;
  logic saw_ready1_low;

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset_ready", 32'(fu_ready), 32'hFF);
    check("reset_tx", 32'(cdbtransmit), 32'h0);

    // Single result from FU3.
    drive_fu(3, 8'h5A, 4'h7, 8'h12);
    tick();
    set_idle();
    tick();
    check("t1_tx", 32'(cdbtransmit), 32'h1);
    check("t1_val", 32'(cdbval), 32'h5A);
    check("t1_id", 32'(cdbid), 32'h7);
    check("t1_rob", 32'(cdbrobid), 32'h12);
    tick();
    check("t1_tx_low", 32'(cdbtransmit), 32'h0);

    // All FUs at once from rr_ptr=0: broadcast order FU0..FU7.
    do_reset();
    for (int i = 0; i < FuCount; i++) drive_fu(i, 8'(8'h30 + i), 4'(i), 8'(8'h80 + i));
    tick();
    set_idle();
    for (int i = 0; i < FuCount; i++) begin
      tick();
      check("t2_order", 32'(cdbid), 32'(i));
    end
    drive_fu(7, 8'hE7, 4'hE, 8'h77);
    drive_fu(0, 8'hE0, 4'hD, 8'h70);
    tick();
    set_idle();
    tick();
    check("t2_rr_wrap", 32'(cdbid), 32'hD);
    tick();
    tick();

    // FU1 and FU2 streaming every cycle.
    do_reset();
    saw_ready1_low = 1'b0;
    for (int c = 0; c < 16; c++) begin
      set_idle();
      drive_fu(1, 8'(c), 4'h1, 8'(8'h10 + c));
      drive_fu(2, 8'(c), 4'h2, 8'(8'h20 + c));
      if (!fu_ready[1]) saw_ready1_low = 1'b1;
      tick();
    end
    check("t3_ready1_dropped", 32'(saw_ready1_low), 32'h1);
    set_idle();
    repeat (8) tick();

    // Fill FU5 to capacity, then flush.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < FuCount; i++) drive_fu(i, 8'($urandom), 4'(i), 8'($urandom));
      tick();
    end
    set_idle();
    check("t4_fu5_full", 32'(fu_ready[5]), 32'h0);
    flush = 1'b1;
    drive_fu(5, 8'hAA, 4'h5, 8'hBB);
    tick();
    set_idle();
    check("t4_flush_tx", 32'(cdbtransmit), 32'h0);
    check("t4_flush_ready", 32'(fu_ready), 32'hFF);
    repeat (6) tick();

    // Reset with three FIFOs holding results.
    do_reset();
    drive_fu(0, 8'h01, 4'h1, 8'h01);
    drive_fu(4, 8'h04, 4'h4, 8'h04);
    drive_fu(6, 8'h06, 4'h6, 8'h06);
    tick();
    tick();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_tx", 32'(cdbtransmit), 32'h0);
    check("t5_rst_val", 32'(cdbval), 32'h0);
    check("t5_rst_ready", 32'(fu_ready), 32'hFF);
    repeat (6) tick();

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 10000; c++) begin
      set_idle();
      for (int i = 0; i < FuCount; i++)
        if ($urandom_range(0, 99) < 35) drive_fu(i, 8'($urandom), 4'($urandom), 8'($urandom));
      if ($urandom_range(0, 299) == 0) flush = 1'b1;
      if ($urandom_range(0, 1999) == 0) rst = 1'b1;
      tick();
    end
    set_idle();
    repeat (3 * FuCount) tick();
    pending = 0;
    for (int i = 0; i < FuCount; i++) pending += model_q[i].size();
    check("drained", 32'(pending), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
